// File: rtl/maxpool2d_2x2_stride2x2.sv
// 2x2 / stride-2 max pooling over a raster-order float32 stream.
// One half-width line buffer holds the even-row horizontal pair maxima.
module maxpool2d_2x2_stride2x2 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 218,
    parameter int IMG_HEIGHT = 218
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Valid_In,
    input  logic [DATA_WIDHT-1:0] Data_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Last_Out
);

    localparam int MSB      = DATA_WIDHT - 1;
    localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_POOL_LAST = COL_W'(2 * (IMG_WIDTH / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_POOL_LAST = ROW_W'(2 * (IMG_HEIGHT / 2) - 1);

    // Sign-magnitude ordering; ties keep a, and +0 beats -0 via the sign rule.
    function automatic logic [DATA_WIDHT-1:0] fmax(input logic [DATA_WIDHT-1:0] a,
                                                   input logic [DATA_WIDHT-1:0] b);
        logic a_wins;
        if (a[MSB] != b[MSB]) begin
            a_wins = ~a[MSB];
        end else if (!a[MSB]) begin
            a_wins = (a[MSB-1:0] >= b[MSB-1:0]);
        end else begin
            a_wins = (a[MSB-1:0] <= b[MSB-1:0]);
        end
        return a_wins ? a : b;
    endfunction

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDHT-1:0] prev_q;
    logic [DATA_WIDHT-1:0] linebuf_q [LB_DEPTH];
    logic [DATA_WIDHT-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  last_out_q, last_out_d;

    logic [DATA_WIDHT-1:0] hmax;
    logic [DATA_WIDHT-1:0] lb_rd;
    logic [LB_AW-1:0]      lb_idx;
    logic                  odd_col, odd_row;

    // An odd final column/row never has its odd partner, so parity alone selects pooled pixels.
    assign odd_col = col_q[0];
    assign odd_row = row_q[0];
    assign lb_idx  = LB_AW'(col_q >> 1);
    assign lb_rd   = linebuf_q[lb_idx];
    assign hmax    = fmax(prev_q, Data_In);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
        if (Valid_In) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (odd_row && odd_col) begin
                data_out_d  = fmax(lb_rd, hmax);
                valid_out_d = 1'b1;
                last_out_d  = (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

    // Datapath storage needs no reset: every entry is written on an even row before use.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            prev_q <= Data_In;
        end
        if (!rst && Valid_In && !odd_row && odd_col) begin
            linebuf_q[lb_idx] <= hmax;
        end
    end

    assign Data_Out  = data_out_q;
    assign Valid_Out = valid_out_q;
    assign Last_Out  = last_out_q;

endmodule

// File: tb/tb_maxpool2d_2x2_stride2x2.sv
// Bench for maxpool2d_2x2_stride2x2: a 4x4 instance and a 5x5 instance checked
// every cycle against a frame-image model, plus hand-computed output lists.
module tb_maxpool2d_2x2_stride2x2;

    logic        clk = 1'b0;
    logic [1:0]  rst_a;
    logic [1:0]  vin;
    logic [31:0] din [2];
    logic [31:0] dout [2];
    logic [1:0]  vout;
    logic [1:0]  lout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    maxpool2d_2x2_stride2x2 #(.DATA_WIDHT(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rst(rst_a[0]), .Valid_In(vin[0]), .Data_In(din[0]),
        .Data_Out(dout[0]), .Valid_Out(vout[0]), .Last_Out(lout[0]));

    maxpool2d_2x2_stride2x2 #(.DATA_WIDHT(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .rst(rst_a[1]), .Valid_In(vin[1]), .Data_In(din[1]),
        .Data_Out(dout[1]), .Valid_Out(vout[1]), .Last_Out(lout[1]));

    // ---------------- model: stores the frame image, pools 2x2 windows ----------------
    function automatic int w_of(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic longint fkey(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] win_max(input logic [31:0] p0, input logic [31:0] p1,
                                            input logic [31:0] p2, input logic [31:0] p3);
        logic [31:0] w [4];
        logic [31:0] best;
        w = '{p0, p1, p2, p3};
        best = w[0];
        for (int k = 1; k < 4; k++) begin
            if (fkey(w[k]) > fkey(best) || (fkey(w[k]) == fkey(best) && !w[k][31] && best[31]))
                best = w[k];
        end
        return best;
    endfunction

    logic [31:0] img [2][5][5];
    int          mrow [2];
    int          mcol [2];
    logic [1:0]  exp_v;
    logic [1:0]  exp_l;
    logic [31:0] exp_d [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int r  = mrow[i];
            automatic int c  = mcol[i];
            automatic int wd = w_of(i);
            automatic int ht = w_of(i);
            if (rst_a[i]) begin
                mrow[i]  <= 0;
                mcol[i]  <= 0;
                exp_v[i] <= 1'b0;
                exp_l[i] <= 1'b0;
            end else if (vin[i]) begin
                img[i][r][c] <= din[i];
                if (r % 2 == 1 && c % 2 == 1 && r < 2 * (ht / 2) && c < 2 * (wd / 2)) begin
                    exp_v[i] <= 1'b1;
                    exp_d[i] <= win_max(img[i][r-1][c-1], img[i][r-1][c], img[i][r][c-1], din[i]);
                    exp_l[i] <= (r == 2 * (ht / 2) - 1) && (c == 2 * (wd / 2) - 1);
                end else begin
                    exp_v[i] <= 1'b0;
                    exp_l[i] <= 1'b0;
                end
                if (c == wd - 1) begin
                    mcol[i] <= 0;
                    mrow[i] <= (r == ht - 1) ? 0 : r + 1;
                end else begin
                    mcol[i] <= c + 1;
                end
            end else begin
                exp_v[i] <= 1'b0;
                exp_l[i] <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    logic [32:0] obs0 [$];
    logic [32:0] obs1 [$];
    logic [32:0] lit  [$];

    task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid_out[%0d]", i), 33'(vout[i]), 33'(exp_v[i]));
            chk($sformatf("last_out[%0d]", i), 33'(lout[i]), 33'(exp_v[i] & exp_l[i]));
            if (exp_v[i]) chk($sformatf("data_out[%0d]", i), 33'(dout[i]), 33'(exp_d[i]));
        end
        if (vout[0]) obs0.push_back({lout[0], dout[0]});
        if (vout[1]) obs1.push_back({lout[1], dout[1]});
    endtask

    task automatic check_obs(input int inst, input string nm);
        int n;
        n = (inst == 0) ? obs0.size() : obs1.size();
        chk({nm, " count"}, 33'(n), 33'(lit.size()));
        for (int k = 0; k < n && k < lit.size(); k++) begin
            chk($sformatf("%s out%0d", nm, k), (inst == 0) ? obs0[k] : obs1[k], lit[k]);
        end
        obs0.delete();
        obs1.delete();
        lit.delete();
    endtask

    task automatic send(input int i, input logic [31:0] px);
        vin[i] = 1'b1;
        din[i] = px;
        tick();
        vin[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] i2f(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = $clog2(n + 1) - 1;
        m = (32'(n) << (23 - e)) & 32'h007f_ffff;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic push_t1_lits();
        lit.push_back({1'b0, 32'h4000_0000});
        lit.push_back({1'b0, 32'h4040_0000});
        lit.push_back({1'b0, 32'h4040_0000});
        lit.push_back({1'b1, 32'h3f80_0000});
    endtask

    logic [31:0] t1 [16] = '{
        32'h3f80_0000, 32'h4000_0000, 32'h3f00_0000, 32'h4040_0000,
        32'h3f00_0000, 32'h3f00_0000, 32'h4000_0000, 32'h3f80_0000,
        32'hbf80_0000, 32'h4040_0000, 32'h3f80_0000, 32'h3f80_0000,
        32'h4000_0000, 32'hc000_0000, 32'hbf80_0000, 32'h3f00_0000};

    logic [31:0] t2 [16] = '{
        32'hbf80_0000, 32'hc000_0000, 32'h8000_0000, 32'h0000_0000,
        32'hc000_0000, 32'hc000_0000, 32'h8000_0000, 32'h8000_0000,
        32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, 32'h7f80_0000,
        32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, 32'h4000_0000};

    initial begin
        rst_a  = 2'b11;
        vin    = 2'b00;
        din[0] = '0;
        din[1] = '0;
        idle(3);
        chk("reset data4", 33'(dout[0]), 33'h0);
        chk("reset data5", 33'(dout[1]), 33'h0);
        chk("reset valid", 33'(vout), 33'h0);
        chk("reset last", 33'(lout), 33'h0);
        rst_a = 2'b00;
        idle(2);

        // basic frame, Valid_In held high
        foreach (t1[k]) send(0, t1[k]);
        idle(3);
        push_t1_lits();
        check_obs(0, "t1");

        // negative values and signed zeros
        foreach (t2[k]) send(0, t2[k]);
        idle(3);
        lit.push_back({1'b0, 32'hbf80_0000});
        lit.push_back({1'b0, 32'h0000_0000});
        lit.push_back({1'b0, 32'h3f80_0000});
        lit.push_back({1'b1, 32'h7f80_0000});
        check_obs(0, "t2");

        // random idle gaps between pixels
        foreach (t1[k]) begin
            send(0, t1[k]);
            idle($urandom_range(1, 3));
        end
        idle(2);
        push_t1_lits();
        check_obs(0, "t3");

        // mid-frame reset, with a valid pixel presented on the reset edge
        for (int k = 0; k < 6; k++) send(0, t1[k]);
        obs0.delete();
        rst_a[0] = 1'b1;
        vin[0]   = 1'b1;
        din[0]   = t1[6];
        tick();
        chk("rst data", 33'(dout[0]), 33'h0);
        rst_a[0] = 1'b0;
        vin[0]   = 1'b0;
        idle(2);
        foreach (t1[k]) send(0, t1[k]);
        idle(3);
        push_t1_lits();
        check_obs(0, "t4");

        // two frames back to back
        for (int f = 0; f < 2; f++) foreach (t1[k]) send(0, t1[k]);
        idle(3);
        push_t1_lits();
        push_t1_lits();
        check_obs(0, "t5");

        // odd geometry 5x5, two frames with no gap
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 25; k++) send(1, i2f(k));
        idle(3);
        for (int f = 0; f < 2; f++) begin
            lit.push_back({1'b0, 32'h40c0_0000});
            lit.push_back({1'b0, 32'h4100_0000});
            lit.push_back({1'b0, 32'h4180_0000});
            lit.push_back({1'b1, 32'h4190_0000});
        end
        check_obs(1, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
